// File: rtl/rv_dmem_arb_pkg.sv
// Types shared by the data-memory arbiter and its helpers.
`include "rv_configs.sv"

package rv_dmem_arb_pkg;

  typedef enum logic [1:0] {
    LgIdle = `DMARB_IDLE,
    LgP0   = `DMARB_P0,
    LgP1   = `DMARB_P1
  } last_gnt_e;

  typedef struct packed {
    logic [`DMEM_A_BIT-1:0] a;
    logic [`XLEN-1:0]       wd;
    logic                   we;
    logic [2:0]             bytectrl;
  } dmem_req_t;

endpackage

// File: rtl/rv_configs.sv
// Shared RV core configuration: datapath widths, data-memory access-size codes
// and the arbiter's last-grant encodings.
`ifndef RV_CONFIGS_SV
`define RV_CONFIGS_SV

`define XLEN       32
`define DMEM_A_BIT 32

`define DMEM_BYTECTRL_B  3'b000
`define DMEM_BYTECTRL_H  3'b001
`define DMEM_BYTECTRL_W  3'b010
`define DMEM_BYTECTRL_BU 3'b100
`define DMEM_BYTECTRL_HU 3'b101

`define DMARB_IDLE 2'd0
`define DMARB_P0   2'd1
`define DMARB_P1   2'd2

`endif

// File: rtl/rv_dmem_align_chk.sv
// Flags word accesses not on a 4-byte boundary and halfword accesses on odd addresses.
`include "rv_configs.sv"

module rv_dmem_align_chk (
  input  logic [1:0] a_lo_i,
  input  logic [2:0] bytectrl_i,
  output logic       misaligned_o
);

  always_comb begin
    misaligned_o = 1'b0;
    case (bytectrl_i)
      `DMEM_BYTECTRL_W:                   misaligned_o = |a_lo_i;
      `DMEM_BYTECTRL_H, `DMEM_BYTECTRL_HU: misaligned_o = a_lo_i[0];
      default:                            misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_dmem_arb.sv
// Two-port data-memory arbiter: p0 has normal priority, p1 wins once it has been
// denied STARVE_LIMIT consecutive cycles. Grant is combinational, ack one cycle later.
`include "rv_configs.sv"

module rv_dmem_arb
  import rv_dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   i_dmarb_clk,
  input  logic                   i_dmarb_rstn,
  input  logic                   i_p0_req,
  input  logic [`DMEM_A_BIT-1:0] i_p0_a,
  input  logic [`XLEN-1:0]       i_p0_wd,
  input  logic                   i_p0_we,
  input  logic [2:0]             i_p0_bytectrl,
  output logic                   o_p0_gnt,
  output logic                   o_p0_ack,
  output logic [`XLEN-1:0]       o_p0_rd,
  output logic                   o_p0_err,
  input  logic                   i_p1_req,
  input  logic [`DMEM_A_BIT-1:0] i_p1_a,
  input  logic [`XLEN-1:0]       i_p1_wd,
  input  logic                   i_p1_we,
  input  logic [2:0]             i_p1_bytectrl,
  output logic                   o_p1_gnt,
  output logic                   o_p1_ack,
  output logic [`XLEN-1:0]       o_p1_rd,
  output logic                   o_p1_err,
  output logic [`DMEM_A_BIT-1:0] o_dmem_a,
  output logic [`XLEN-1:0]       o_dmem_wd,
  output logic                   o_dmem_we,
  output logic [2:0]             o_dmem_bytectrl,
  input  logic [`XLEN-1:0]       i_dmem_rd
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  logic [3:0]       starve_cnt_q, starve_cnt_d;
  last_gnt_e        last_gnt_q, last_gnt_d;
  logic             err_q, err_d;
  logic [`XLEN-1:0] p0_rd_q, p0_rd_d, p1_rd_q, p1_rd_d;

  logic             starve_flag, gnt0, gnt1, p0_mis, p1_mis, sel_mis;
  logic [`XLEN-1:0] load_data;
  dmem_req_t        sel_req;

  rv_dmem_align_chk u_align_p0 (
    .a_lo_i       (i_p0_a[1:0]),
    .bytectrl_i   (i_p0_bytectrl),
    .misaligned_o (p0_mis)
  );

  rv_dmem_align_chk u_align_p1 (
    .a_lo_i       (i_p1_a[1:0]),
    .bytectrl_i   (i_p1_bytectrl),
    .misaligned_o (p1_mis)
  );

  always_comb begin
    starve_flag = (starve_cnt_q == StarveLimit);
    gnt1        = i_p1_req & (starve_flag | ~i_p0_req);
    gnt0        = i_p0_req & ~gnt1;

    sel_req = '0;
    sel_mis = 1'b0;
    if (gnt1) begin
      sel_req = '{a: i_p1_a, wd: i_p1_wd, we: i_p1_we, bytectrl: i_p1_bytectrl};
      sel_mis = p1_mis;
    end else if (gnt0) begin
      sel_req = '{a: i_p0_a, wd: i_p0_wd, we: i_p0_we, bytectrl: i_p0_bytectrl};
      sel_mis = p0_mis;
    end

    o_p0_gnt        = gnt0;
    o_p1_gnt        = gnt1;
    o_dmem_a        = sel_req.a;
    o_dmem_wd       = sel_req.wd;
    o_dmem_we       = sel_req.we & ~sel_mis;
    o_dmem_bytectrl = sel_req.bytectrl;

    // Stores and faulted accesses return zero rather than whatever memory drives.
    load_data = (sel_mis | sel_req.we) ? '0 : i_dmem_rd;
    p0_rd_d   = gnt0 ? load_data : p0_rd_q;
    p1_rd_d   = gnt1 ? load_data : p1_rd_q;
    err_d     = sel_mis;

    if (!i_p1_req || gnt1) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < StarveLimit) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = starve_cnt_q;
    end

    if (gnt1) begin
      last_gnt_d = LgP1;
    end else if (gnt0) begin
      last_gnt_d = LgP0;
    end else begin
      last_gnt_d = LgIdle;
    end

    o_p0_ack = (last_gnt_q == LgP0);
    o_p1_ack = (last_gnt_q == LgP1);
    o_p0_err = o_p0_ack & err_q;
    o_p1_err = o_p1_ack & err_q;
    o_p0_rd  = p0_rd_q;
    o_p1_rd  = p1_rd_q;
  end

  always_ff @(posedge i_dmarb_clk or negedge i_dmarb_rstn) begin
    if (!i_dmarb_rstn) begin
      starve_cnt_q <= 4'd0;
      last_gnt_q   <= LgIdle;
      err_q        <= 1'b0;
      p0_rd_q      <= '0;
      p1_rd_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_gnt_q   <= last_gnt_d;
      err_q        <= err_d;
      p0_rd_q      <= p0_rd_d;
      p1_rd_q      <= p1_rd_d;
    end
  end

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Scoreboard bench for rv_dmem_arb: stimulus queues expected acks, a monitor checks them.
module tb_rv_dmem_arb;

  localparam logic [2:0] BcW = 3'b010;
  localparam logic [2:0] BcH = 3'b001;

  logic        clk = 1'b0;
  logic        rstn;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_a, p0_wd, p1_a, p1_wd;
  logic [2:0]  p0_bc, p1_bc;
  logic        p0_gnt, p0_ack, p0_err, p1_gnt, p1_ack, p1_err;
  logic [31:0] p0_rd, p1_rd;
  logic [31:0] dm_a, dm_wd, dm_rd;
  logic        dm_we;
  logic [2:0]  dm_bc;

  logic [31:0] mem [0:63];
  logic        mem_init_done = 1'b0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] exp_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_dmem_arb #(.STARVE_LIMIT(4)) dut (
    .i_dmarb_clk     (clk),
    .i_dmarb_rstn    (rstn),
    .i_p0_req        (p0_req),
    .i_p0_a          (p0_a),
    .i_p0_wd         (p0_wd),
    .i_p0_we         (p0_we),
    .i_p0_bytectrl   (p0_bc),
    .o_p0_gnt        (p0_gnt),
    .o_p0_ack        (p0_ack),
    .o_p0_rd         (p0_rd),
    .o_p0_err        (p0_err),
    .i_p1_req        (p1_req),
    .i_p1_a          (p1_a),
    .i_p1_wd         (p1_wd),
    .i_p1_we         (p1_we),
    .i_p1_bytectrl   (p1_bc),
    .o_p1_gnt        (p1_gnt),
    .o_p1_ack        (p1_ack),
    .o_p1_rd         (p1_rd),
    .o_p1_err        (p1_err),
    .o_dmem_a        (dm_a),
    .o_dmem_wd       (dm_wd),
    .o_dmem_we       (dm_we),
    .o_dmem_bytectrl (dm_bc),
    .i_dmem_rd       (dm_rd)
  );

  // Memory model: combinational word read, byte-lane write on the clock edge.
  assign dm_rd = mem[dm_a[7:2]];

  always @(posedge clk) begin
    logic [31:0] w;
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
      mem[0] <= 32'h1111_1111;
      mem[1] <= 32'h2222_2222;
      mem[4] <= 32'hDEAD_BEEF;
      mem[5] <= 32'hCAFE_F00D;
      mem[8] <= 32'h5566_7788;
      mem_init_done <= 1'b1;
    end else if (dm_we) begin
      w = mem[dm_a[7:2]];
      case (dm_bc)
        3'b000:  w[8*int'(dm_a[1:0]) +: 8] = dm_wd[7:0];
        3'b001:  w[16*int'(dm_a[1]) +: 16] = dm_wd[15:0];
        default: w = dm_wd;
      endcase
      mem[dm_a[7:2]] <= w;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_p0(input logic req, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [2:0] bc);
    p0_req = req; p0_a = a; p0_wd = wd; p0_we = we; p0_bc = bc;
  endtask

  task automatic set_p1(input logic req, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [2:0] bc);
    p1_req = req; p1_a = a; p1_wd = wd; p1_we = we; p1_bc = bc;
  endtask

  // Check grants mid-cycle, then advance to just after the next rising edge.
  task automatic step(input logic g0, input logic g1, input string name);
    @(negedge clk);
    chk({name, "_gnt0"}, 32'(p0_gnt), 32'(g0));
    chk({name, "_gnt1"}, 32'(p1_gnt), 32'(g1));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (p0_ack) begin
        if (q0.size() == 0) chk("p0_ack_unexpected", 32'(p0_ack), 32'd0);
        else begin
          exp_e = q0.pop_front();
          chk("p0_rd", p0_rd, exp_e[31:0]);
          chk("p0_err", 32'(p0_err), 32'(exp_e[32]));
        end
      end else if (p0_err) chk("p0_err_without_ack", 32'(p0_err), 32'd0);
      if (p1_ack) begin
        if (q1.size() == 0) chk("p1_ack_unexpected", 32'(p1_ack), 32'd0);
        else begin
          exp_e = q1.pop_front();
          chk("p1_rd", p1_rd, exp_e[31:0]);
          chk("p1_err", 32'(p1_err), 32'(exp_e[32]));
        end
      end else if (p1_err) chk("p1_err_without_ack", 32'(p1_err), 32'd0);
    end
  end

  initial begin
    logic [9:0] pat;
    logic [4:0] pat2;
    rstn = 1'b0;
    set_p0(0, 0, 0, 0, BcW);
    set_p1(0, 0, 0, 0, BcW);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_p0_ack", 32'(p0_ack), 0);
    chk("rst_p1_ack", 32'(p1_ack), 0);
    chk("rst_p0_rd", p0_rd, 0);
    chk("rst_p1_rd", p1_rd, 0);
    chk("rst_err", 32'({p0_err, p1_err}), 0);
    chk("rst_gnt", 32'({p0_gnt, p1_gnt}), 0);
    chk("idle_dmem_a", dm_a, 0);
    chk("idle_dmem_wd_we_bc", {dm_wd[27:0], dm_we, dm_bc}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Aligned load on p0.
    set_p0(1, 32'h10, 0, 0, BcW);
    q0.push_back({1'b0, 32'hDEAD_BEEF});
    #1 chk("lw_dmem_a", dm_a, 32'h10);
    step(1, 0, "lw");
    set_p0(0, 0, 0, 0, BcW);

    // Both requesting: p1 wins every fifth cycle.
    pat = 10'b10000_10000;
    set_p0(1, 32'h00, 0, 0, BcW);
    set_p1(1, 32'h04, 0, 0, BcW);
    for (int i = 0; i < 10; i++) begin
      if (pat[i]) q1.push_back({1'b0, 32'h2222_2222});
      else        q0.push_back({1'b0, 32'h1111_1111});
      step(!pat[i], pat[i], "starve");
    end
    set_p0(0, 0, 0, 0, BcW);
    set_p1(0, 0, 0, 0, BcW);

    // p1 halfword store then p0 word load, back to back.
    set_p1(1, 32'h22, 32'hABCD_1234, 1, BcH);
    q1.push_back({1'b0, 32'h0});
    #1 chk("sh_dmem_we", 32'(dm_we), 1);
    step(0, 1, "sh");
    set_p1(0, 0, 0, 0, BcW);
    set_p0(1, 32'h20, 0, 0, BcW);
    q0.push_back({1'b0, 32'h1234_7788});
    step(1, 0, "lw_after_sh");
    set_p0(0, 0, 0, 0, BcW);
    step(0, 0, "drain_sh");
    chk("mem8_after_sh", mem[8], 32'h1234_7788);
    chk("p0_rd_hold", p0_rd, 32'h1234_7788);

    // Misaligned accesses.
    set_p0(1, 32'h13, 0, 0, BcW);
    q0.push_back({1'b1, 32'h0});
    #1 chk("mis_lw_we", 32'(dm_we), 0);
    step(1, 0, "mis_lw");
    set_p0(1, 32'h16, 32'hFFFF_FFFF, 1, BcW);
    q0.push_back({1'b1, 32'h0});
    #1 chk("mis_sw_we", 32'(dm_we), 0);
    step(1, 0, "mis_sw");
    set_p0(0, 0, 0, 0, BcW);
    set_p1(1, 32'h21, 0, 0, BcH);
    q1.push_back({1'b1, 32'h0});
    step(0, 1, "mis_lh");
    set_p1(0, 0, 0, 0, BcW);
    step(0, 0, "drain_mis");
    chk("mem4_unchanged", mem[4], 32'hDEAD_BEEF);
    chk("mem5_unchanged", mem[5], 32'hCAFE_F00D);

    // Reset right after a p1 grant kills its ack.
    set_p1(1, 32'h04, 0, 0, BcW);
    step(0, 1, "pre_rst_p1");
    rstn = 1'b0;
    #1;
    chk("rst_kill_p1_ack", 32'(p1_ack), 0);
    chk("rst_p1_rd", p1_rd, 0);
    chk("rst_gnt_comb", 32'(p1_gnt), 1);
    set_p1(0, 0, 0, 0, BcW);
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("starve_cnt_after_rst", 32'(dut.starve_cnt_q), 0);

    // Reset must clear a partially built starvation count.
    set_p0(1, 32'h00, 0, 0, BcW);
    set_p1(1, 32'h04, 0, 0, BcW);
    q0.push_back({1'b0, 32'h1111_1111});
    q0.push_back({1'b0, 32'h1111_1111});
    for (int i = 0; i < 3; i++) step(1, 0, "pre_rst_cnt");
    rstn = 1'b0;
    set_p0(0, 0, 0, 0, BcW);
    set_p1(0, 0, 0, 0, BcW);
    @(posedge clk);
    #1 rstn = 1'b1;
    pat2 = 5'b10000;
    set_p0(1, 32'h00, 0, 0, BcW);
    set_p1(1, 32'h04, 0, 0, BcW);
    for (int i = 0; i < 5; i++) begin
      if (pat2[i]) q1.push_back({1'b0, 32'h2222_2222});
      else         q0.push_back({1'b0, 32'h1111_1111});
      step(!pat2[i], pat2[i], "post_rst_starve");
    end
    set_p0(0, 0, 0, 0, BcW);
    set_p1(0, 0, 0, 0, BcW);
    step(0, 0, "final_drain");
    step(0, 0, "final_idle");

    chk("q0_leftover", 32'(q0.size()), 0);
    chk("q1_leftover", 32'(q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
